ddr_mem_initiator: RTL and testbench

DDR_MEM_INITIATOR -- requirements
Module: ddr_mem_initiator

---
 rtl/ddr_mem_initiator.sv | 128 ++++++++++++
 tb/tb_ddr_mem_initiator.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_mem_initiator.sv
// Host-to-memory request initiator: one outstanding read or write at a time,
// with a registered response channel and saturating completion counters.
module ddr_mem_initiator #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_wr,
    output logic                  mem_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_response,
    output logic [15:0]           wr_cnt,
    output logic [15:0]           rd_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WACK,
        READ,
        RCAP,
        RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_write_q, rsp_write_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_write ? WRITE : READ;
                end
            end
            WRITE: state_d = WACK;
            WACK: begin
                // the memory acknowledges in the cycle after the strobe
                rsp_err_d   = ~mem_response;
                rsp_write_d = 1'b1;
                rsp_rdata_d = '0;
                state_d     = RESP;
            end
            READ: state_d = RCAP;
            RCAP: begin
                rsp_rdata_d = mem_rdata;
                rsp_write_d = 1'b0;
                rsp_err_d   = 1'b0;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    if (rsp_write_q) begin
                        if (!(&wr_cnt_q)) wr_cnt_d = wr_cnt_q + 16'd1;
                    end else begin
                        if (!(&rd_cnt_q)) rd_cnt_d = rd_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    // every output is a decode of the state register or a flop
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign mem_wr    = (state_q == WRITE);
    assign mem_rd    = (state_q == READ);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rsp_write = rsp_write_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign wr_cnt    = wr_cnt_q;
    assign rd_cnt    = rd_cnt_q;

endmodule

// File: tb/tb_ddr_mem_initiator.sv
// Randomised bench for ddr_mem_initiator: a simple memory device plus a
// transaction-level reference of memory contents and completion counts.
module tb_ddr_mem_initiator;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready, rsp_write, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          mem_wr, mem_rd, mem_response;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   wr_cnt, rd_cnt;

    ddr_mem_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wr(mem_wr), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_response(mem_response),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
    );

    always #5 clk = ~clk;

    // memory device: ack one cycle after a write strobe, data one cycle
    // after a read strobe, random junk on the data bus otherwise
    logic [DW-1:0] dev_mem [16];
    logic          ack_q = 1'b0, rdv_q = 1'b0, kill_ack = 1'b0;
    logic [DW-1:0] rdd_q = '0, junk_q = '0;

    always @(posedge clk) begin
        junk_q <= $urandom;
        if (mem_wr) dev_mem[mem_addr] <= mem_wdata;
        ack_q <= mem_wr && !kill_ack;
        rdv_q <= mem_rd;
        if (mem_rd) rdd_q <= dev_mem[mem_addr];
    end
    assign mem_rdata    = rdv_q ? rdd_q : junk_q;
    assign mem_response = ack_q;

    // reference model
    logic [DW-1:0] ref_mem [16];
    int unsigned   ref_wr, ref_rd;
    int            n_vec = 0, n_err = 0;

    function automatic int unsigned sat(input int unsigned v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic run_txn(input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int hold,
                           input bit intrude, output int lat,
                           output logic o_w, output logic [DW-1:0] o_rd,
                           output logic o_err, output int wp, output int rp,
                           output int unstable, output int rdy_bad);
        lat = -1; wp = 0; rp = 0; unstable = 0; rdy_bad = 0;
        o_w = 1'bx; o_rd = 'x; o_err = 1'bx;
        @(negedge clk);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        rsp_ready = 0;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        req_valid = 0; req_write = 1'($urandom);
        req_addr = AW'($urandom); req_wdata = $urandom;
        for (int n = 1; n <= 8; n++) begin
            wp += int'(mem_wr); rp += int'(mem_rd);
            if (rsp_valid) begin lat = n - 1; break; end
            @(negedge clk);
        end
        o_w = rsp_write; o_rd = rsp_rdata; o_err = rsp_err;
        repeat (hold) begin
            if (intrude) begin
                req_valid = 1; req_write = 1'($urandom);
                req_addr = AW'($urandom); req_wdata = $urandom;
            end
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_write !== o_w ||
                rsp_rdata !== o_rd || rsp_err !== o_err) unstable++;
            if (req_ready !== 1'b0) rdy_bad++;
            wp += int'(mem_wr); rp += int'(mem_rd);
        end
        req_valid = 0; rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        wp += int'(mem_wr); rp += int'(mem_rd);
    endtask

    task automatic test_reset;
        n_vec++;
        if (req_ready !== 1'b1) begin n_err++;
            $display("FAIL reset_req_ready got %0b want 1", req_ready); end
        n_vec++;
        if ({rsp_valid, rsp_write, rsp_err, mem_wr, mem_rd} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags got %b want 00000",
                {rsp_valid, rsp_write, rsp_err, mem_wr, mem_rd}); end
        n_vec++;
        if (wr_cnt !== 16'd0 || rd_cnt !== 16'd0 || mem_addr !== '0 ||
            mem_wdata !== '0 || rsp_rdata !== '0) begin n_err++;
            $display("FAIL reset_regs wr %0h rd %0h addr %0h wd %0h rdata %0h want 0",
                wr_cnt, rd_cnt, mem_addr, mem_wdata, rsp_rdata); end
    endtask

    task automatic test_write_read;
        int lat, wp, rp, us, rb; logic ow, oe; logic [DW-1:0] od;
        run_txn(1, 4'd3, 32'hDEADBEEF, 0, 0, lat, ow, od, oe, wp, rp, us, rb);
        ref_mem[3] = 32'hDEADBEEF; ref_wr = sat(ref_wr);
        n_vec++;
        if (lat !== 2) begin n_err++;
            $display("FAIL wr_latency got %0d want 2", lat); end
        n_vec++;
        if (wp !== 1 || rp !== 0) begin n_err++;
            $display("FAIL wr_strobes wr %0d rd %0d want 1 0", wp, rp); end
        n_vec++;
        if (ow !== 1'b1 || oe !== 1'b0 || od !== '0) begin n_err++;
            $display("FAIL wr_rsp w %0b err %0b rdata %0h want 1 0 0", ow, oe, od); end
        n_vec++;
        if (wr_cnt !== 16'(ref_wr)) begin n_err++;
            $display("FAIL wr_cnt got %0d want %0d", wr_cnt, ref_wr); end
        run_txn(0, 4'd3, '0, 0, 0, lat, ow, od, oe, wp, rp, us, rb);
        ref_rd = sat(ref_rd);
        n_vec++;
        if (lat !== 2 || wp !== 0 || rp !== 1) begin n_err++;
            $display("FAIL rd_timing lat %0d wr %0d rd %0d want 2 0 1", lat, wp, rp); end
        n_vec++;
        if (od !== 32'hDEADBEEF || ow !== 1'b0 || oe !== 1'b0) begin n_err++;
            $display("FAIL rd_rsp rdata %0h w %0b err %0b want deadbeef 0 0", od, ow, oe); end
        n_vec++;
        if (rd_cnt !== 16'(ref_rd)) begin n_err++;
            $display("FAIL rd_cnt got %0d want %0d", rd_cnt, ref_rd); end
    endtask

    task automatic test_write_err;
        int lat, wp, rp, us, rb; logic ow, oe; logic [DW-1:0] od, d;
        logic [AW-1:0] a;
        a = AW'($urandom); d = $urandom;
        kill_ack = 1;
        run_txn(1, a, d, 0, 0, lat, ow, od, oe, wp, rp, us, rb);
        kill_ack = 0;
        ref_mem[a] = d; ref_wr = sat(ref_wr);
        n_vec++;
        if (oe !== 1'b1 || ow !== 1'b1) begin n_err++;
            $display("FAIL noack_err err %0b w %0b want 1 1", oe, ow); end
        n_vec++;
        if (wr_cnt !== 16'(ref_wr)) begin n_err++;
            $display("FAIL noack_wr_cnt got %0d want %0d", wr_cnt, ref_wr); end
    endtask

    task automatic test_stall;
        int lat, wp, rp, us, rb; logic ow, oe; logic [DW-1:0] od;
        run_txn(0, 4'd3, '0, 5, 1, lat, ow, od, oe, wp, rp, us, rb);
        ref_rd = sat(ref_rd);
        n_vec++;
        if (us !== 0 || rb !== 0) begin n_err++;
            $display("FAIL stall_stable unstable %0d ready_high %0d want 0 0", us, rb); end
        n_vec++;
        if (od !== ref_mem[3] || wp !== 0 || rp !== 1) begin n_err++;
            $display("FAIL stall_rsp rdata %0h wr %0d rd %0d want %0h 0 1",
                od, wp, rp, ref_mem[3]); end
        n_vec++;
        if (wr_cnt !== 16'(ref_wr) || rd_cnt !== 16'(ref_rd)) begin n_err++;
            $display("FAIL stall_cnt wr %0d rd %0d want %0d %0d",
                wr_cnt, rd_cnt, ref_wr, ref_rd); end
    endtask

    task automatic test_random;
        int lat, wp, rp, us, rb; logic ow, oe, w; logic [DW-1:0] od, d, exp_d;
        logic [AW-1:0] a;
        for (int k = 0; k < 24; k++) begin
            w = 1'($urandom); a = AW'($urandom); d = $urandom;
            run_txn(w, a, d, int'($urandom_range(0, 3)), 1'($urandom),
                    lat, ow, od, oe, wp, rp, us, rb);
            if (w) begin ref_mem[a] = d; ref_wr = sat(ref_wr); exp_d = '0; end
            else begin exp_d = ref_mem[a]; ref_rd = sat(ref_rd); end
            n_vec++;
            if (lat !== 2 || ow !== w || od !== exp_d || oe !== 1'b0 ||
                wp !== int'(w) || rp !== int'(!w) || us !== 0 || rb !== 0) begin
                n_err++;
                $display("FAIL rand_%0d lat %0d w %0b rdata %0h err %0b wp %0d rp %0d us %0d want 2 %0b %0h 0 %0d %0d 0",
                    k, lat, ow, od, oe, wp, rp, us, w, exp_d, int'(w), int'(!w));
            end
            n_vec++;
            if (wr_cnt !== 16'(ref_wr) || rd_cnt !== 16'(ref_rd)) begin n_err++;
                $display("FAIL rand_cnt_%0d wr %0d rd %0d want %0d %0d",
                    k, wr_cnt, rd_cnt, ref_wr, ref_rd); end
        end
    endtask

    task automatic test_back_to_back;
        logic          exp_w [$];
        logic [DW-1:0] exp_d [$];
        logic          ew;
        logic [DW-1:0] ed;
        int last = -1, acc = 0, bad_gap = 0, bad_rsp = 0;
        bit acc_now;
        @(negedge clk);
        rsp_ready = 1; req_valid = 1; req_write = 1'($urandom);
        req_addr = AW'($urandom); req_wdata = $urandom;
        for (int cyc = 0; cyc < 80 && (acc < 6 || exp_w.size() > 0); cyc++) begin
            acc_now = 0;
            if (rsp_valid) begin
                if (exp_w.size() == 0) bad_rsp++;
                else begin
                    ew = exp_w.pop_front(); ed = exp_d.pop_front();
                    if (rsp_write !== ew || rsp_rdata !== ed || rsp_err !== 1'b0)
                        bad_rsp++;
                    if (ew) ref_wr = sat(ref_wr); else ref_rd = sat(ref_rd);
                end
            end
            if (req_valid && req_ready) begin
                if (last >= 0 && cyc - last != 4) bad_gap++;
                last = cyc; acc++; acc_now = 1;
                if (req_write) begin
                    ref_mem[req_addr] = req_wdata;
                    exp_w.push_back(1'b1); exp_d.push_back('0);
                end else begin
                    exp_w.push_back(1'b0); exp_d.push_back(ref_mem[req_addr]);
                end
            end
            @(negedge clk);
            if (acc_now) begin
                req_valid = (acc < 6); req_write = 1'($urandom);
                req_addr = AW'($urandom); req_wdata = $urandom;
            end
        end
        rsp_ready = 0; req_valid = 0;
        n_vec++;
        if (acc !== 6 || exp_w.size() !== 0) begin n_err++;
            $display("FAIL b2b_done accepted %0d pending %0d want 6 0", acc, exp_w.size()); end
        n_vec++;
        if (bad_gap !== 0 || bad_rsp !== 0) begin n_err++;
            $display("FAIL b2b_gap_rsp bad_gap %0d bad_rsp %0d want 0 0", bad_gap, bad_rsp); end
        n_vec++;
        if (wr_cnt !== 16'(ref_wr) || rd_cnt !== 16'(ref_rd)) begin n_err++;
            $display("FAIL b2b_cnt wr %0d rd %0d want %0d %0d",
                wr_cnt, rd_cnt, ref_wr, ref_rd); end
    endtask

    task automatic test_saturate;
        int lat, wp, rp, us, rb; logic ow, oe; logic [DW-1:0] od;
        @(negedge clk);
        force dut.wr_cnt_q = 16'hFFFE;
        #1;
        release dut.wr_cnt_q;
        ref_wr = 65534;
        for (int k = 0; k < 2; k++) begin
            run_txn(1, AW'(k), 32'h5A5A0000 + 32'(k), 0, 0,
                    lat, ow, od, oe, wp, rp, us, rb);
            ref_mem[k] = 32'h5A5A0000 + 32'(k); ref_wr = sat(ref_wr);
            n_vec++;
            if (wr_cnt !== 16'(ref_wr)) begin n_err++;
                $display("FAIL sat_wr_cnt_%0d got %0h want %0h", k, wr_cnt, ref_wr); end
        end
        n_vec++;
        if (rd_cnt !== 16'(ref_rd)) begin n_err++;
            $display("FAIL sat_rd_cnt got %0d want %0d", rd_cnt, ref_rd); end
    endtask

    task automatic test_reset_mid_read;
        int seen = 0, rds = 0;
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 4'd3; rsp_ready = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        n_vec++;
        if (mem_rd !== 1'b1) begin n_err++;
            $display("FAIL midrd_strobe got %0b want 1", mem_rd); end
        reset = 1;
        #1;
        ref_wr = 0; ref_rd = 0;
        n_vec++;
        if (mem_rd !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL midrd_async rd %0b ready %0b valid %0b want 0 1 0",
                mem_rd, req_ready, rsp_valid); end
        n_vec++;
        if (wr_cnt !== 16'(ref_wr) || rd_cnt !== 16'(ref_rd)) begin n_err++;
            $display("FAIL midrd_cnt wr %0d rd %0d want 0 0", wr_cnt, rd_cnt); end
        @(negedge clk);
        reset = 0;
        repeat (6) begin
            @(negedge clk);
            seen += int'(rsp_valid); rds += int'(mem_rd);
        end
        n_vec++;
        if (seen !== 0 || rds !== 0 || req_ready !== 1'b1) begin n_err++;
            $display("FAIL midrd_after valid %0d rd %0d ready %0b want 0 0 1",
                seen, rds, req_ready); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin dev_mem[i] = '0; ref_mem[i] = '0; end
        ref_wr = 0; ref_rd = 0;
        reset = 1; req_valid = 0; req_write = 0; req_addr = '0;
        req_wdata = '0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        test_reset;
        reset = 0;
        test_write_read;
        test_write_err;
        test_stall;
        test_random;
        test_back_to_back;
        test_saturate;
        test_reset_mid_read;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
